// File: rtl/prefetch_stream_buffer.sv
// Next-line instruction prefetcher with a DEPTH-entry FIFO stream buffer.
// Sits between the I-cache miss port and the arbiter. Buffer hits are answered in the same cycle.
module prefetch_stream_buffer #(
    parameter int DEPTH        = 4,
    parameter int STRIDE_BYTES = 32,
    parameter int LINE_BITS    = 256,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     inst_pmem_address,
    input  logic                      inst_pmem_read,
    output logic                      pf_resp,
    output logic [LINE_BITS-1:0]      pf_rdata,
    input  logic                      inst_pmem_resp,
    input  logic [LINE_BITS-1:0]      inst_pmem_rdata,
    output logic                      pf_read,
    output logic [ADDR_WIDTH-1:0]     pf_address,
    input  logic                      pf_enable,
    input  logic                      pf_flush,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(STRIDE_BYTES);
    localparam logic [OCC_W-1:0]      OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]      OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_d [DEPTH];
    logic [LINE_BITS-1:0]   data_q [DEPTH];
    logic [LINE_BITS-1:0]   data_d [DEPTH];
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [ADDR_WIDTH-1:0]  next_fetch_q, next_fetch_d;
    logic                   drop_q, drop_d;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;

    logic                   match_found;
    logic [PTR_W-1:0]       match_idx;
    logic [PTR_W-1:0]       match_dist;
    logic [DEPTH-1:0]       pop_mask;
    logic                   buf_full;

    assign buf_full   = (occ_q == OCC_FULL);
    assign match_dist = match_idx - head_q;
    assign occupancy  = occ_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!match_found && valid_q[k] && (addr_q[k] == inst_pmem_address)) begin
                match_found = 1'b1;
                match_idx   = PTR_W'(k);
            end
        end
    end

    // A hit retires the matching entry together with every entry that was pushed before it.
    always_comb begin
        pop_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (PTR_W'(PTR_W'(k) - head_q) <= match_dist) begin
                pop_mask[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        next_fetch_d = next_fetch_q;
        drop_d       = drop_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        pf_resp      = 1'b0;
        pf_rdata     = '0;
        pf_read      = 1'b0;
        pf_address   = '0;

        unique case (state_q)
            IDLE: begin
                if (pf_flush) begin
                    valid_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    occ_d   = '0;
                    if (inst_pmem_read) begin
                        next_fetch_d = inst_pmem_address + STRIDE;
                        state_d      = MISS;
                    end
                end else if (inst_pmem_read && match_found) begin
                    pf_resp  = 1'b1;
                    pf_rdata = data_q[match_idx];
                    valid_d  = valid_q & ~pop_mask;
                    head_d   = match_idx + PTR_ONE;
                    occ_d    = occ_q - (OCC_W'(match_dist) + OCC_ONE);
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end
                end else if (inst_pmem_read) begin
                    valid_d      = '0;
                    head_d       = '0;
                    tail_d       = '0;
                    occ_d        = '0;
                    next_fetch_d = inst_pmem_address + STRIDE;
                    state_d      = MISS;
                end else if (pf_enable && !buf_full) begin
                    state_d = FILL;
                end
            end

            MISS: begin
                pf_read    = 1'b1;
                pf_address = inst_pmem_address;
                if (pf_flush) begin
                    valid_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    occ_d   = '0;
                end
                if (inst_pmem_resp) begin
                    pf_resp  = inst_pmem_read;
                    pf_rdata = inst_pmem_read ? inst_pmem_rdata : '0;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                    state_d = IDLE;
                end
            end

            FILL: begin
                pf_read    = 1'b1;
                pf_address = next_fetch_q;
                if (pf_flush) begin
                    valid_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    occ_d   = '0;
                    drop_d  = 1'b1;
                end
                // A flush on the response cycle discards the line just like an earlier one would.
                if (inst_pmem_resp) begin
                    if (!drop_q && !pf_flush && !buf_full) begin
                        addr_d[tail_q]  = next_fetch_q;
                        data_d[tail_q]  = inst_pmem_rdata;
                        valid_d[tail_q] = 1'b1;
                        tail_d          = tail_q + PTR_ONE;
                        occ_d           = occ_q + OCC_ONE;
                    end
                    next_fetch_d = next_fetch_q + STRIDE;
                    drop_d       = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            next_fetch_q <= '0;
            drop_q       <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            next_fetch_q <= next_fetch_d;
            drop_q       <= drop_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

endmodule
